// File: rtl/seq_divider_16.sv
// Multi-cycle unsigned restoring divider producing quotient (LO) and remainder (HI) for DIVU.
// One trial subtraction per cycle; results are registered and held until the next divide completes.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;

    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign diff  = trial - {1'b0, divisor_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    // FIN publishes the working registers and can accept a new divide in the same cycle,
    // so completion of the old result and loading of new operands share one edge.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, FIN: begin
                if (state_q == FIN) begin
                    quotient_d  = quo_q;
                    remainder_d = rem_q;
                    dbz_d       = zero_q;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else if (start) begin
                    dbz_d = 1'b0;
                end

                if (start) begin
                    divisor_d = divisor;
                    if (divisor != '0) begin
                        state_d = RUN;
                        count_d = CNT_W'(WIDTH - 1);
                        rem_d   = '0;
                        quo_d   = dividend;
                        zero_d  = 1'b0;
                    end else begin
                        state_d = ZERO;
                        rem_d   = dividend;
                        quo_d   = '1;
                        zero_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == '0) begin
                    state_d = FIN;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end

            ZERO: begin
                state_d = FIN;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == RUN) || (state_q == ZERO);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
